ram_delta_banked_wrap: RTL and testbench
========================================

// Module: ram_delta_banked_wrap
// PURPOSE
//  Banked on-chip buffer built from N single-port SRAM banks, presenting one write port and one read port with valid/ready handshakes.
//  Bank = low BANK_BIT address bits (interleaved). A 1-entry write buffer absorbs same-bank read/write collisions.
//  A 2-entry output FIFO holds read data until the consumer takes it.
//  Replaces plain per-array SRAM wrappers in the SYA/CPM datapath where producer and consumer share one array.
// PARAMETERS
//  ADDR_BIT   8              word address width
//  DEPTH      2**ADDR_BIT    total words, split evenly across banks
//  WIDTH      128            data width in bits
//  BYTES      16             write-mask lanes; WIDTH % BYTES == 0
//  BANK_BIT   1              log2(number of banks); 0 = single bank
// PORTS
//  clk         in   1           clock
//  rst_n       in   1           asynchronous active-low reset
//  wr_vld      in   1           write request valid
//  wr_rdy      out  1           write request accepted when wr_vld & wr_rdy
//  wr_addr     in   ADDR_BIT    write word address
//  wr_dat      in   WIDTH       write data
//  wr_bmask    in   BYTES       per-lane write enable, 1 = write lane
//  rd_vld      in   1           read request valid
//  rd_rdy      out  1           read request accepted when rd_vld & rd_rdy
//  rd_addr     in   ADDR_BIT    read word address
//  rd_dat_vld  out  1           read data valid
//  rd_dat_rdy  in   1           consumer takes data when rd_dat_vld & rd_dat_rdy
//  rd_dat      out  WIDTH       read data, stable while rd_dat_vld & ~rd_dat_rdy
//  busy        out  1           write buffer occupied
// BEHAVIOUR
//  Reset: wr_rdy=1, rd_rdy=1, rd_dat_vld=0, busy=0, rd_dat=0. Write buffer, in-flight flag and FIFO are cleared.
//  Reset mid-operation: drop in-flight reads and any buffered write. SRAM contents are never reset.
//  Banks: single-port, 1 access per cycle. Read data appears on the bank DO one cycle after the access.
//  Per-cycle bank priority:
//   (1) an accepted read;
//   (2) write-buffer drain;
//   (3) direct write of the incoming request.
//  rd_rdy = (fifo_cnt + inflight) < 2 & ~hazard.
//   hazard = buf_vld & (rd_addr == buf_addr). Compare against buffer contents at start of cycle.
//  Read latency: accepted at cycle t -> rd_dat_vld at t+1.
//   FIFO empty: rd_dat is taken straight from bank DO.
//   Otherwise: data queued behind the FIFO head; strict issue order.
//  wr_rdy = ~buf_vld | buf_drain. buf_drain = buf_vld & no accepted read to buf bank this cycle.
//  Accepted write routing:
//   - Bank free this cycle (no read, no drain to same bank): write SRAM directly; buffer unchanged.
//   - Otherwise: enter buffer (addr, dat, bmask); busy=1 from next cycle.
//  Same-cycle read and write to the same address: the read wins and returns OLD data. The write is buffered.
//  Hazard without RAM_BYPASS_EN: rd_rdy=0 for that cycle and the buffer drains (no competing read).
//   The read is accepted the next cycle, so there is a 1-cycle bubble.
//  Byte mask: only lanes with bmask=1 are written. bmask=0 on all lanes is accepted and writes nothing.
//  Full/empty: FIFO at 2 entries with rd_dat_rdy=0 -> rd_rdy=0. FIFO never overflows.
//   Simultaneous FIFO pop and push keeps the count unchanged.
//  Addresses wrap modulo DEPTH; there is no out-of-range detection.
// CONFIGURATION
//  RAM_BYPASS_EN defined:
//   - A hazard does not stall; rd_rdy ignores hazard.
//   - The read proceeds to SRAM. Buffered lanes (buf_bmask=1) replace SRAM lanes when the data enters the FIFO/output.
//   - Buffer-drain priority is unchanged.
//  RAM_BYPASS_EN undefined: stall-and-drain behaviour as above; no merge logic.
// STRUCTURE
//  ram_delta_pkg:
//   - bank_of(addr) and row_of(addr) functions;
//   - localparams NBANK=2**BANK_BIT, ROW_BIT=ADDR_BIT-BANK_BIT, LANE_W=WIDTH/BYTES;
//   - struct wr_req_t {addr, dat, bmask}.
//  Sub-module ram_delta_bank: single-port bank, 2**ROW_BIT x WIDTH, with CSB/WEB(BYTES)/A/DI/DO and 1-cycle read.
//   Instantiated NBANK times via generate.
//  Top holds: arbitration, write buffer, in-flight bank/valid register, 2-entry FIFO, bypass merge.
// TESTING
//  T1 reset: assert rst_n=0 mid-stream -> next cycle wr_rdy=1, rd_rdy=1, rd_dat_vld=0, busy=0.
//   After release, a read of a previously written address returns the written data.
//  T2 stream: write addr 0..255 with data=addr*3, full mask.
//   Then read 0..255 back-to-back with rd_dat_rdy=1 -> 1 result/cycle, latency 1, data=addr*3.
//  T3 collision: same cycle rd_addr=4, wr_addr=6 (bank 0).
//   -> read accepted; write buffered with busy=1; drain next cycle with busy=0; re-read 6 returns new data.
//  T4 hazard: buffer holds addr 6 = 0xAA.., then read 6.
//   Bypass off: rd_rdy=0 for 1 cycle, then data 0xAA...
//   Bypass on: no stall, data 0xAA...
//  T5 backpressure: rd_dat_rdy=0 with 3 reads issued -> rd_rdy=0 after 2; rd_dat holds the first word.
//   Release -> words emerge in order, none lost.
//  T6 mask: write 0xFF.. full mask, then write 0x00.. with bmask=16'h00FF -> read gives upper 8 lanes 0xFF, lower 8 lanes 0x00.

Source files
------------

// File: rtl/ram_delta_pkg.sv
// Shared geometry, request type and address helpers for the banked delta buffer.
package ram_delta_pkg;
   localparam int ADDR_BIT = 8;
   localparam int DEPTH    = 2**ADDR_BIT;
   localparam int WIDTH    = 128;
   localparam int BYTES    = 16;
   localparam int BANK_BIT = 1;
   localparam int NBANK    = 2**BANK_BIT;
   localparam int ROW_BIT  = ADDR_BIT - BANK_BIT;
   localparam int LANE_W   = WIDTH / BYTES;
   // A single-bank build still needs a 1-bit bank index to keep the muxes legal.
   localparam int BIDX_W   = (BANK_BIT == 0) ? 1 : BANK_BIT;

   typedef logic [ADDR_BIT-1:0] addr_t;
   typedef logic [BIDX_W-1:0]   bank_t;
   typedef logic [ROW_BIT-1:0]  row_t;

   typedef struct packed {
      addr_t              addr;
      logic [WIDTH-1:0]   dat;
      logic [BYTES-1:0]   bmask;
   } wr_req_t;

   function automatic bank_t bank_of(input addr_t addr);
      addr_t m;
      m = addr_t'(NBANK - 1);
      return bank_t'(addr & m);
   endfunction

   function automatic row_t row_of(input addr_t addr);
      return row_t'(addr >> BANK_BIT);
   endfunction

   function automatic logic [WIDTH-1:0] lane_merge(input logic [WIDTH-1:0] base,
                                                   input logic [WIDTH-1:0] over,
                                                   input logic [BYTES-1:0] mask);
      logic [WIDTH-1:0] r;
      r = base;
      for (int i = 0; i < BYTES; i++)
         if (mask[i]) r[i*LANE_W +: LANE_W] = over[i*LANE_W +: LANE_W];
      return r;
   endfunction
endpackage

// File: rtl/ram_delta_bank.sv
// Single-port SRAM bank model: active-low select and per-lane write enables, 1-cycle read.
module ram_delta_bank
   import ram_delta_pkg::*;
(
   input  logic              clk,
   input  logic              csb,
   input  logic [BYTES-1:0]  web,
   input  logic [ROW_BIT-1:0] a,
   input  logic [WIDTH-1:0]  di,
   output logic [WIDTH-1:0]  dout
);
   logic [WIDTH-1:0] mem [2**ROW_BIT];

   // A selected cycle with no lane enabled is a read; dout holds otherwise.
   always_ff @(posedge clk) begin
      if (!csb) begin
         if (&web) dout <= mem[a];
         for (int i = 0; i < BYTES; i++)
            if (!web[i]) mem[a][i*LANE_W +: LANE_W] <= di[i*LANE_W +: LANE_W];
      end
   end
endmodule

// File: rtl/ram_delta_banked_wrap.sv
// Banked buffer: read/write arbitration, 1-entry write buffer, 2-entry read FIFO.
// Optional RAM_BYPASS_EN: reads hitting the write buffer merge buffered lanes instead of stalling.
module ram_delta_banked_wrap
   import ram_delta_pkg::*;
(
   input  logic                clk,
   input  logic                rst_n,
   input  logic                wr_vld,
   output logic                wr_rdy,
   input  logic [ADDR_BIT-1:0] wr_addr,
   input  logic [WIDTH-1:0]    wr_dat,
   input  logic [BYTES-1:0]    wr_bmask,
   input  logic                rd_vld,
   output logic                rd_rdy,
   input  logic [ADDR_BIT-1:0] rd_addr,
   output logic                rd_dat_vld,
   input  logic                rd_dat_rdy,
   output logic [WIDTH-1:0]    rd_dat,
   output logic                busy
);
   // Handshakes: a transfer happens on a rising edge where valid & ready are both high;
   // the requester holds its payload stable until then, ready never depends on a later edge.
   wr_req_t          buf_q;
   logic             buf_vld;
   logic             infl_vld;
   bank_t            infl_bank;
   logic [WIDTH-1:0] fifo_q [2];
   logic [1:0]       fifo_cnt;

   bank_t            rd_bank, wr_bank, buf_bank;
   logic             hazard, rd_acc, wr_acc, buf_drain, wr_direct, wr_to_buf;
   logic [1:0]       occ;
   logic [WIDTH-1:0] rd_word;
   logic             fifo_pop, fifo_push, direct_take;

   logic [NBANK-1:0] bank_csb;
   logic [BYTES-1:0] bank_web [NBANK];
   row_t             bank_a   [NBANK];
   logic [WIDTH-1:0] bank_di  [NBANK];
   logic [WIDTH-1:0] bank_do  [NBANK];

`ifdef RAM_BYPASS_EN
   logic infl_hit;
`endif

   assign rd_bank  = bank_of(rd_addr);
   assign wr_bank  = bank_of(wr_addr);
   assign buf_bank = bank_of(buf_q.addr);
   assign hazard   = buf_vld && (rd_addr == buf_q.addr);
   assign occ      = fifo_cnt + {1'b0, infl_vld};

`ifdef RAM_BYPASS_EN
   assign rd_rdy = (occ < 2'd2);
`else
   assign rd_rdy = (occ < 2'd2) && !hazard;
`endif

   assign rd_acc    = rd_vld && rd_rdy;
   assign buf_drain = buf_vld && !(rd_acc && (rd_bank == buf_bank));
   assign wr_rdy    = !buf_vld || buf_drain;
   assign wr_acc    = wr_vld && wr_rdy;
   assign wr_direct = wr_acc && !(rd_acc && (rd_bank == wr_bank))
                             && !(buf_drain && (buf_bank == wr_bank));
   assign wr_to_buf = wr_acc && !wr_direct;
   assign busy      = buf_vld;

   // Per-bank port: read beats buffer drain beats direct write.
   always_comb begin
      for (int b = 0; b < NBANK; b++) begin
         bank_csb[b] = 1'b1;
         bank_web[b] = '1;
         bank_a[b]   = '0;
         bank_di[b]  = '0;
         if (rd_acc && (rd_bank == bank_t'(b))) begin
            bank_csb[b] = 1'b0;
            bank_a[b]   = row_of(rd_addr);
         end else if (buf_drain && (buf_bank == bank_t'(b))) begin
            bank_csb[b] = 1'b0;
            bank_web[b] = ~buf_q.bmask;
            bank_a[b]   = row_of(buf_q.addr);
            bank_di[b]  = buf_q.dat;
         end else if (wr_direct && (wr_bank == bank_t'(b))) begin
            bank_csb[b] = 1'b0;
            bank_web[b] = ~wr_bmask;
            bank_a[b]   = row_of(wr_addr);
            bank_di[b]  = wr_dat;
         end
      end
   end

   for (genvar g = 0; g < NBANK; g++) begin : g_bank
      ram_delta_bank u_bank (
         .clk  (clk),
         .csb  (bank_csb[g]),
         .web  (bank_web[g]),
         .a    (bank_a[g]),
         .di   (bank_di[g]),
         .dout (bank_do[g])
      );
   end

   // A hit read blocks its bank's drain and wr_rdy, so the buffer is unchanged when data returns.
`ifdef RAM_BYPASS_EN
   assign rd_word = infl_hit ? lane_merge(bank_do[infl_bank], buf_q.dat, buf_q.bmask)
                             : bank_do[infl_bank];
`else
   assign rd_word = bank_do[infl_bank];
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         buf_vld   <= 1'b0;
         buf_q     <= '0;
         infl_vld  <= 1'b0;
         infl_bank <= '0;
`ifdef RAM_BYPASS_EN
         infl_hit  <= 1'b0;
`endif
      end else begin
         if (wr_to_buf) begin
            buf_vld <= 1'b1;
            buf_q   <= '{addr: wr_addr, dat: wr_dat, bmask: wr_bmask};
         end else if (buf_drain) begin
            buf_vld <= 1'b0;
         end
         infl_vld <= rd_acc;
         if (rd_acc) infl_bank <= rd_bank;
`ifdef RAM_BYPASS_EN
         infl_hit <= rd_acc && hazard;
`endif
      end
   end

   // Bank data goes straight out when the FIFO is empty, otherwise it queues behind the head.
   assign fifo_pop    = (fifo_cnt != 2'd0) && rd_dat_rdy;
   assign direct_take = (fifo_cnt == 2'd0) && infl_vld && rd_dat_rdy;
   assign fifo_push   = infl_vld && !direct_take;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fifo_cnt  <= 2'd0;
         fifo_q[0] <= '0;
         fifo_q[1] <= '0;
      end else if (fifo_pop) begin
         if (fifo_cnt == 2'd2) fifo_q[0] <= fifo_q[1];
         else if (fifo_push)   fifo_q[0] <= rd_word;
         fifo_cnt <= fifo_cnt - 2'd1 + {1'b0, fifo_push};
      end else if (fifo_push) begin
         if (fifo_cnt == 2'd0) fifo_q[0] <= rd_word;
         else                  fifo_q[1] <= rd_word;
         fifo_cnt <= fifo_cnt + 2'd1;
      end
   end

   assign rd_dat_vld = (fifo_cnt != 2'd0) || infl_vld;
   assign rd_dat     = (fifo_cnt != 2'd0) ? fifo_q[0] : (infl_vld ? rd_word : '0);
endmodule

// File: tb/tb_ram_delta_banked_wrap.sv
// Bench for ram_delta_banked_wrap: directed corner cases, a vector table and random traffic
// checked against a flat memory model with an expected-read queue.
module tb_ram_delta_banked_wrap;
   logic         clk = 1'b0;
   logic         rst_n;
   logic         wr_vld, wr_rdy;
   logic [7:0]   wr_addr;
   logic [127:0] wr_dat;
   logic [15:0]  wr_bmask;
   logic         rd_vld, rd_rdy;
   logic [7:0]   rd_addr;
   logic         rd_dat_vld, rd_dat_rdy;
   logic [127:0] rd_dat;
   logic         busy;

   int checks = 0;
   int errors = 0;

   logic [127:0] model_mem [256];
   logic [127:0] exp_q [$];
   logic         prev_hold = 1'b0;
   logic [127:0] prev_dat;

   typedef struct {
      logic [7:0]   addr;
      logic [127:0] dat;
      logic [15:0]  bmask;
      logic [127:0] exp;
   } vec_t;
   vec_t vecs [6];

   ram_delta_banked_wrap dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .wr_vld     (wr_vld),
      .wr_rdy     (wr_rdy),
      .wr_addr    (wr_addr),
      .wr_dat     (wr_dat),
      .wr_bmask   (wr_bmask),
      .rd_vld     (rd_vld),
      .rd_rdy     (rd_rdy),
      .rd_addr    (rd_addr),
      .rd_dat_vld (rd_dat_vld),
      .rd_dat_rdy (rd_dat_rdy),
      .rd_dat     (rd_dat),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [127:0] rand128();
      return {$urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   // Scoreboard: reads see memory as of their accept cycle, before a same-cycle write.
   always @(negedge clk) begin
      if (!rst_n) begin
         exp_q.delete();
         prev_hold = 1'b0;
      end else begin
         if (prev_hold) begin
            check("hold_vld", 128'(rd_dat_vld), 128'(1));
            check("hold_dat", rd_dat, prev_dat);
         end
         if (rd_dat_vld && rd_dat_rdy) begin
            if (exp_q.size() == 0) check("unexpected_data", 128'(1), 128'(0));
            else check("sb_data", rd_dat, exp_q.pop_front());
         end
         prev_hold = rd_dat_vld && !rd_dat_rdy;
         prev_dat  = rd_dat;
         if (rd_vld && rd_rdy) exp_q.push_back(model_mem[rd_addr]);
         if (wr_vld && wr_rdy)
            for (int l = 0; l < 16; l++)
               if (wr_bmask[l]) model_mem[wr_addr][l*8 +: 8] = wr_dat[l*8 +: 8];
      end
   end

   task automatic do_write(input logic [7:0] a, input logic [127:0] d, input logic [15:0] m);
      int n;
      n = 0;
      @(posedge clk); #1;
      wr_vld = 1'b1; wr_addr = a; wr_dat = d; wr_bmask = m;
      @(negedge clk);
      while (!wr_rdy && n < 20) begin @(negedge clk); n++; end
      check("wr_accept", 128'(wr_rdy), 128'(1));
      @(posedge clk); #1;
      wr_vld = 1'b0;
   endtask

   task automatic do_read(input logic [7:0] a, output logic [127:0] d);
      int n;
      n = 0;
      @(posedge clk); #1;
      rd_vld = 1'b1; rd_addr = a; rd_dat_rdy = 1'b1;
      @(negedge clk);
      while (!rd_rdy && n < 20) begin @(negedge clk); n++; end
      check("rd_accept", 128'(rd_rdy), 128'(1));
      @(posedge clk); #1;
      rd_vld = 1'b0;
      n = 0;
      @(negedge clk);
      while (!rd_dat_vld && n < 20) begin @(negedge clk); n++; end
      check("rd_latency", 128'(n), 128'(0));
      d = rd_dat;
   endtask

   initial begin
      logic [127:0] d;
      logic [127:0] got [3];
      int stalls, bad, ngot;
      logic acc, wr_done, rd_done;

      vecs[0] = '{8'd10,  {16{8'hFF}}, 16'hFFFF, {16{8'hFF}}};
      vecs[1] = '{8'd10,  128'h0,      16'h00FF, {{8{8'hFF}}, {8{8'h00}}}};
      vecs[2] = '{8'd10,  rand128(),   16'h0000, {{8{8'hFF}}, {8{8'h00}}}};
      vecs[3] = '{8'd11,  {16{8'hA5}}, 16'hFFFF, {16{8'hA5}}};
      vecs[4] = '{8'd11,  {16{8'h5A}}, 16'hF0F0, 128'h5A5A5A5A_A5A5A5A5_5A5A5A5A_A5A5A5A5};
      vecs[5] = '{8'd255, 128'h01234567_89ABCDEF_FEDCBA98_76543210, 16'hFFFF,
                  128'h01234567_89ABCDEF_FEDCBA98_76543210};

      rst_n = 1'b0; wr_vld = 1'b0; wr_addr = '0; wr_dat = '0; wr_bmask = '0;
      rd_vld = 1'b0; rd_addr = '0; rd_dat_rdy = 1'b1;
      for (int i = 0; i < 256; i++) model_mem[i] = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_wr_rdy", 128'(wr_rdy), 128'(1));
      check("rst_rd_rdy", 128'(rd_rdy), 128'(1));
      check("rst_rd_dat_vld", 128'(rd_dat_vld), 128'(0));
      check("rst_busy", 128'(busy), 128'(0));
      check("rst_rd_dat", rd_dat, 128'h0);
      @(posedge clk); #1; rst_n = 1'b1;

      // Stream: fill then read everything back-to-back
      for (int i = 0; i < 256; i++) do_write(i[7:0], 128'(i * 3), 16'hFFFF);
      stalls = 0; bad = 0;
      for (int i = 0; i <= 256; i++) begin
         @(posedge clk); #1;
         rd_vld = (i < 256); rd_addr = i[7:0];
         @(negedge clk);
         if (i < 256 && !rd_rdy) stalls++;
         if (i > 0 && (!rd_dat_vld || rd_dat !== 128'((i - 1) * 3))) bad++;
      end
      @(posedge clk); #1; rd_vld = 1'b0;
      check("stream_stalls", 128'(stalls), 128'(0));
      check("stream_data", 128'(bad), 128'(0));

      // Collision: read 4 and write 6 share bank 0
      @(posedge clk); #1;
      rd_vld = 1'b1; rd_addr = 8'd4;
      wr_vld = 1'b1; wr_addr = 8'd6; wr_dat = {4{32'hC0FFEE11}}; wr_bmask = 16'hFFFF;
      @(negedge clk);
      check("coll_rd_rdy", 128'(rd_rdy), 128'(1));
      check("coll_wr_rdy", 128'(wr_rdy), 128'(1));
      @(posedge clk); #1; rd_vld = 1'b0; wr_vld = 1'b0;
      @(negedge clk);
      check("coll_busy", 128'(busy), 128'(1));
      check("coll_rd_vld", 128'(rd_dat_vld), 128'(1));
      check("coll_rd_dat", rd_dat, 128'd12);
      @(posedge clk); #1;
      @(negedge clk);
      check("coll_drained", 128'(busy), 128'(0));
      do_read(8'd6, d);
      check("coll_reread", d, {4{32'hC0FFEE11}});

      // Hazard: buffer holds addr 6 when it is read
      @(posedge clk); #1;
      rd_vld = 1'b1; rd_addr = 8'd4;
      wr_vld = 1'b1; wr_addr = 8'd6; wr_dat = {16{8'hAA}}; wr_bmask = 16'hFFFF;
      @(negedge clk);
      check("haz_setup_rdy", 128'(rd_rdy && wr_rdy), 128'(1));
      @(posedge clk); #1; wr_vld = 1'b0; rd_addr = 8'd6;
      @(negedge clk);
      check("haz_busy", 128'(busy), 128'(1));
`ifdef RAM_BYPASS_EN
      check("haz_no_stall", 128'(rd_rdy), 128'(1));
      @(posedge clk); #1; rd_vld = 1'b0;
      @(negedge clk);
      check("haz_vld", 128'(rd_dat_vld), 128'(1));
      check("haz_dat", rd_dat, {16{8'hAA}});
      check("haz_busy_hold", 128'(busy), 128'(1));
      @(posedge clk); #1;
      @(negedge clk);
      check("haz_drained", 128'(busy), 128'(0));
`else
      check("haz_stall", 128'(rd_rdy), 128'(0));
      @(posedge clk); #1;
      @(negedge clk);
      check("haz_accept", 128'(rd_rdy), 128'(1));
      check("haz_drained", 128'(busy), 128'(0));
      @(posedge clk); #1; rd_vld = 1'b0;
      @(negedge clk);
      check("haz_vld", 128'(rd_dat_vld), 128'(1));
      check("haz_dat", rd_dat, {16{8'hAA}});
`endif

      // Backpressure: three reads with the consumer stalled
      @(posedge clk); #1; rd_dat_rdy = 1'b0; rd_vld = 1'b1; rd_addr = 8'd20;
      @(negedge clk); check("bp_rdy0", 128'(rd_rdy), 128'(1));
      @(posedge clk); #1; rd_addr = 8'd21;
      @(negedge clk); check("bp_rdy1", 128'(rd_rdy), 128'(1));
      @(posedge clk); #1; rd_addr = 8'd22;
      @(negedge clk);
      check("bp_full", 128'(rd_rdy), 128'(0));
      check("bp_head", rd_dat, 128'd60);
      @(posedge clk); #1;
      @(negedge clk);
      check("bp_still_full", 128'(rd_rdy), 128'(0));
      check("bp_head_hold", rd_dat, 128'd60);
      acc = 1'b0; ngot = 0;
      for (int c = 0; c < 20 && ngot < 3; c++) begin
         @(posedge clk); #1;
         if (acc) rd_vld = 1'b0;
         rd_dat_rdy = 1'b1;
         @(negedge clk);
         if (rd_vld && rd_rdy) acc = 1'b1;
         if (rd_dat_vld) begin got[ngot] = rd_dat; ngot++; end
      end
      @(posedge clk); #1; rd_vld = 1'b0;
      check("bp_count", 128'(ngot), 128'(3));
      check("bp_w0", got[0], 128'd60);
      check("bp_w1", got[1], 128'd63);
      check("bp_w2", got[2], 128'd66);

      // Vector table: masked writes, each read back
      for (int v = 0; v < 6; v++) begin
         do_write(vecs[v].addr, vecs[v].dat, vecs[v].bmask);
         do_read(vecs[v].addr, d);
         check($sformatf("vec%0d", v), d, vecs[v].exp);
      end

      // Reset with reads in flight
      @(posedge clk); #1; rd_dat_rdy = 1'b0; rd_vld = 1'b1; rd_addr = 8'd30;
      @(negedge clk);
      @(posedge clk); #1; rd_addr = 8'd31;
      @(negedge clk);
      @(posedge clk); #1; rd_vld = 1'b0; rst_n = 1'b0;
      @(negedge clk);
      check("mid_rst_wr_rdy", 128'(wr_rdy), 128'(1));
      check("mid_rst_rd_rdy", 128'(rd_rdy), 128'(1));
      check("mid_rst_rd_dat_vld", 128'(rd_dat_vld), 128'(0));
      check("mid_rst_busy", 128'(busy), 128'(0));
      @(posedge clk); #1; rst_n = 1'b1; rd_dat_rdy = 1'b1;
      do_read(8'd6, d);
      check("post_rst_read", d, {16{8'hAA}});

      // Random traffic on a small address window to force collisions
      wr_done = 1'b0; rd_done = 1'b0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         @(posedge clk); #1;
         if (wr_done) wr_vld = 1'b0;
         if (rd_done) rd_vld = 1'b0;
         if (!wr_vld && $urandom_range(0, 1) == 1) begin
            wr_vld = 1'b1; wr_addr = 8'($urandom_range(0, 15)); wr_dat = rand128();
            wr_bmask = ($urandom_range(0, 3) == 0) ? 16'($urandom()) : 16'hFFFF;
         end
         if (!rd_vld && $urandom_range(0, 1) == 1) begin
            rd_vld = 1'b1; rd_addr = 8'($urandom_range(0, 15));
         end
         rd_dat_rdy = ($urandom_range(0, 3) != 0);
         @(negedge clk);
         wr_done = wr_vld && wr_rdy;
         rd_done = rd_vld && rd_rdy;
      end
      @(posedge clk); #1;
      if (wr_done) wr_vld = 1'b0;
      if (rd_done) rd_vld = 1'b0;
      // A still-pending request is withdrawn; the scoreboard only tracks accepted ones.
      wr_vld = 1'b0; rd_vld = 1'b0; rd_dat_rdy = 1'b1;
      for (int c = 0; c < 20 && exp_q.size() != 0; c++) @(negedge clk);
      @(negedge clk);
      check("drain_empty", 128'(exp_q.size()), 128'(0));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
